// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int LINE_W_DEF      = 128;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  // Request attributes captured at arbitration time; address is kept separately
  // because its width is a module parameter.
  typedef struct packed {
    logic        wr;
    logic [1:0]  word_id;
    logic [31:0] wdata;
  } req_attr_t;

  // D-cache wins when it is the only requester or when it holds priority.
  function automatic logic pick_d(input logic i_req, input logic d_req, input logic prio_d);
    return d_req & (~i_req | prio_d);
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Grant-phase watchdog: cleared on grant, counts while enabled, flags expiry
// once TIMEOUT_CYC-1 is reached and holds there.
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (en_i && !expire_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one data-memory port, one transaction
// at a time. Define ARB_ROUND_ROBIN_EN for alternating priority; default is D over I.
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LINE_W      = LINE_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_done_o,
  input  logic              d_req_i,
  input  logic              d_wr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [1:0]        d_word_id_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_done_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic              mem_r_req_o,
  output logic              mem_w_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_word_id_o,
  output logic [31:0]       mem_wr_data_o,
  input  logic              mem_comp_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              arb_busy_o,
  output logic              timeout_err_o
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  req_attr_t         attr_q, attr_d;
  logic              owner_d_q, owner_d_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ctr_clr, ctr_en, ctr_expire;
  logic              prio_d;
  logic              grant;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_d_q, prio_d_d;
  assign prio_d = prio_d_q;
`else
  assign prio_d = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    attr_d    = attr_q;
    owner_d_d = owner_d_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d_d  = prio_d_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_req_i || d_req_i) begin
          ctr_clr = 1'b1;
          if (pick_d(i_req_i, d_req_i, prio_d)) begin
            owner_d_d = 1'b1;
            addr_d    = d_addr_i;
            attr_d    = '{wr: d_wr_i, word_id: d_word_id_i, wdata: d_wdata_i};
            state_d   = ST_GRANT_D;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d_d  = 1'b0;
`endif
          end else begin
            owner_d_d = 1'b0;
            addr_d    = i_addr_i;
            attr_d    = '{wr: 1'b0, word_id: 2'd0, wdata: 32'd0};
            state_d   = ST_GRANT_I;
`ifdef ARB_ROUND_ROBIN_EN
            prio_d_d  = 1'b1;
`endif
          end
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        ctr_en = 1'b1;
        // Completion wins over a same-cycle expiry so the line is not lost.
        if (mem_comp_i) begin
          rdata_d = mem_data_i;
          state_d = ST_RESP;
        end else if (ctr_expire) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      attr_q    <= '0;
      owner_d_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      attr_q    <= attr_d;
      owner_d_q <= owner_d_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio_d_q <= 1'b1;
    else          prio_d_q <= prio_d_d;
  end
`endif

  arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expire_o (ctr_expire)
  );

  // All port-facing controls decode from state so reset clears them at once.
  assign i_gnt_o       = (state_q == ST_GRANT_I);
  assign d_gnt_o       = (state_q == ST_GRANT_D);
  assign grant         = i_gnt_o | d_gnt_o;
  assign i_done_o      = (state_q == ST_RESP) & ~owner_d_q;
  assign d_done_o      = (state_q == ST_RESP) &  owner_d_q;
  assign mem_r_req_o   = grant & ~attr_q.wr;
  assign mem_w_req_o   = grant &  attr_q.wr;
  assign mem_addr_o    = grant ? addr_q         : '0;
  assign mem_word_id_o = grant ? attr_q.word_id : 2'd0;
  assign mem_wr_data_o = grant ? attr_q.wdata   : 32'd0;
  assign arb_busy_o    = (state_q != ST_IDLE);
  assign timeout_err_o = err_q;
  assign rdata_o       = rdata_q;

endmodule
